rpn_stack_ctrl: RTL and testbench

Sequencing controller for the 16-bit RPN calculator ALU. It accepts a stream of tokens (operand pushes and operator codes), keeps the operand stack, and drives the ALU's `op`/`left`/`right` inputs from registered stack values. It consumes the ALU's `ans` and `arg_cnt` to update the stack. It sits between the UART token parser and the ALU, and exposes the stack top and error status to the UART response formatter.

---
 rtl/rpn_stack_ctrl.sv | 150 +++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_ctrl.sv
// RPN calculator sequencer: owns the operand stack, launches registered operands
// into the external ALU, and folds the ALU answer back into the stack.
module rpn_stack_ctrl #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_is_op,
  input  logic [W-1:0]  in_data,
  output logic [3:0]    alu_op,
  output logic [W-1:0]  alu_left,
  output logic [W-1:0]  alu_right,
  input  logic [W-1:0]  alu_ans,
  input  logic [1:0]    alu_arg_cnt,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          result_valid,
  output logic          err,
  output logic [2:0]    err_code
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_D = DW'(DEPTH);
  localparam logic [3:0]    OP_DIV  = 4'd3;

  localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
  localparam logic [2:0] ERR_UNKNOWN   = 3'd3;
  localparam logic [2:0] ERR_DIV_ZERO  = 3'd4;

  typedef enum logic {IDLE, EXEC} state_e;

  state_e state, state_next;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] idx_push, idx_top, idx_second;
  logic [DW-1:0] cnt_ext;

  logic       push;
  logic       launch;
  logic       commit;
  logic       write_ans;
  logic       raise;
  logic [2:0] raise_code;

  assign in_ready   = (state == IDLE);
  assign idx_push   = AW'(depth);
  assign idx_top    = AW'(depth - DW'(1));
  assign idx_second = AW'(depth - DW'(2));
  assign cnt_ext    = DW'(alu_arg_cnt);
  assign top        = (depth == '0) ? '0 : mem[idx_top];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    push       = 1'b0;
    launch     = 1'b0;
    commit     = 1'b0;
    write_ans  = 1'b0;
    raise      = 1'b0;
    raise_code = 3'd0;
    case (state)
      IDLE: begin
        if (in_valid && !clear) begin
          if (in_is_op) begin
            launch     = 1'b1;
            state_next = EXEC;
          end else if (depth < DEPTH_D) begin
            push = 1'b1;
          end else begin
            raise      = 1'b1;
            raise_code = ERR_OVERFLOW;
          end
        end
      end
      EXEC: begin
        state_next = IDLE;
        if (alu_arg_cnt == 2'd0) begin
          raise      = 1'b1;
          raise_code = ERR_UNKNOWN;
        end else if (depth < cnt_ext) begin
          raise      = 1'b1;
          raise_code = ERR_UNDERFLOW;
        end else if (alu_op == OP_DIV && alu_right == '0) begin
          raise      = 1'b1;
          raise_code = ERR_DIV_ZERO;
        end else begin
          commit    = 1'b1;
          write_ans = alu_arg_cnt[1];
        end
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth        <= '0;
      alu_op       <= 4'hF;
      alu_left     <= '0;
      alu_right    <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= 3'd0;
    end else begin
      result_valid <= 1'b0;
      if (clear) begin
        depth    <= '0;
        err      <= 1'b0;
        err_code <= 3'd0;
      end else begin
        if (push) depth <= depth + DW'(1);
        if (launch) begin
          alu_op    <= in_data[3:0];
          alu_left  <= (depth >= DW'(2)) ? mem[idx_second] : '0;
          alu_right <= (depth >= DW'(1)) ? mem[idx_top]    : '0;
        end
        if (commit) begin
          depth        <= depth - DW'(1);
          result_valid <= 1'b1;
        end
        if (raise && !err) begin
          err      <= 1'b1;
          err_code <= raise_code;
        end
      end
    end
  end

  // NOTE: stack storage is deliberately not reset; entries at or above depth are never observed.
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      if (push)      mem[idx_push]   <= in_data;
      if (write_ans) mem[idx_second] <= alu_ans;
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Self-checking bench for rpn_stack_ctrl: directed scenarios plus a randomized
// token stream, compared against a queue-based model of the calculator.
module tb_rpn_stack_ctrl;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic          in_is_op;
  logic [W-1:0]  in_data;
  logic [3:0]    alu_op;
  logic [W-1:0]  alu_left;
  logic [W-1:0]  alu_right;
  logic [W-1:0]  alu_ans;
  logic [1:0]    alu_arg_cnt;
  logic [W-1:0]  top;
  logic [DW-1:0] depth;
  logic          result_valid;
  logic          err;
  logic [2:0]    err_code;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model[$];
  logic         m_err;
  logic [2:0]   m_code;

  always #5 clk = ~clk;

  rpn_stack_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_op(in_is_op), .in_data(in_data),
    .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
    .alu_ans(alu_ans), .alu_arg_cnt(alu_arg_cnt),
    .top(top), .depth(depth), .result_valid(result_valid),
    .err(err), .err_code(err_code)
  );

  // Stand-in for the ALU the controller drives.
  always_comb begin
    alu_ans     = '0;
    alu_arg_cnt = 2'd0;
    case (alu_op)
      4'd0: begin alu_ans = alu_left + alu_right; alu_arg_cnt = 2'd2; end
      4'd1: begin alu_ans = alu_left - alu_right; alu_arg_cnt = 2'd2; end
      4'd2: begin alu_ans = alu_left * alu_right; alu_arg_cnt = 2'd2; end
      4'd3: begin alu_ans = (alu_right != '0) ? alu_left / alu_right : '0; alu_arg_cnt = 2'd2; end
      4'd4: begin alu_ans = alu_right; alu_arg_cnt = 2'd1; end
      default: ;
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_top();
    return (model.size() == 0) ? '0 : model[model.size() - 1];
  endfunction

  task automatic note_err(input logic [2:0] code);
    if (!m_err) begin
      m_err  = 1'b1;
      m_code = code;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_depth"}, 32'(depth), 32'(model.size()));
    check({tag, "_top"}, 32'(top), 32'(m_top()));
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_code"}, 32'(err_code), 32'(m_code));
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // All tasks start and end at a falling edge.
  task automatic push_tok(input logic [W-1:0] v, input string tag);
    in_valid = 1'b1;
    in_is_op = 1'b0;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    if (model.size() < DEPTH) model.push_back(v);
    else                      note_err(3'd1);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check_state(tag);
  endtask

  task automatic op_tok(input logic [3:0] code, input string tag);
    int           n;
    int           need;
    int           ecode;
    logic [W-1:0] l, r, res;
    n     = model.size();
    l     = (n >= 2) ? model[n-2] : '0;
    r     = (n >= 1) ? model[n-1] : '0;
    res   = '0;
    need  = 0;
    ecode = 0;
    case (code)
      4'd0: begin need = 2; res = l + r; end
      4'd1: begin need = 2; res = l - r; end
      4'd2: begin need = 2; res = W'(32'(l) * 32'(r)); end
      4'd3: begin need = 2; res = (r != 0) ? l / r : '0; end
      4'd4: need = 1;
      default: need = 0;
    endcase
    if (need == 0)                  ecode = 3;
    else if (n < need)              ecode = 2;
    else if (code == 4'd3 && r == 0) ecode = 4;

    in_valid = 1'b1;
    in_is_op = 1'b1;
    in_data  = {W'($urandom) & W'(16'hFFF0)} | W'(code);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_exec_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_exec_op"}, 32'(alu_op), 32'(code));
    check({tag, "_exec_left"}, 32'(alu_left), 32'(l));
    check({tag, "_exec_right"}, 32'(alu_right), 32'(r));
    @(negedge clk);
    check({tag, "_rv"}, 32'(result_valid), 32'(ecode == 0));
    if (ecode != 0) begin
      note_err(3'(ecode));
    end else if (need == 2) begin
      void'(model.pop_back());
      void'(model.pop_back());
      model.push_back(res);
    end else begin
      void'(model.pop_back());
    end
    check_state(tag);
  endtask

  task automatic idle_cycle(input string tag);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check_state(tag);
  endtask

  task automatic do_clear(input logic with_token, input string tag);
    clear    = 1'b1;
    in_valid = with_token;
    in_is_op = 1'b0;
    in_data  = 16'h5A5A;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    model.delete();
    m_err  = 1'b0;
    m_code = 3'd0;
    check_state(tag);
  endtask

  initial begin
    logic [3:0] op_table [7];
    op_table = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'hA, 4'h7};
    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_is_op = 1'b0;
    in_data  = '0;
    m_err    = 1'b0;
    m_code   = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_alu_op", 32'(alu_op), 32'hF);
    check("reset_alu_left", 32'(alu_left), 32'd0);
    check("reset_alu_right", 32'(alu_right), 32'd0);
    check("reset_rv", 32'(result_valid), 32'd0);
    check_state("reset");

    // 3 + 4
    push_tok(16'd3, "add_p3");
    push_tok(16'd4, "add_p4");
    op_tok(4'd0, "add_op");
    check("add_top7", 32'(top), 32'd7);
    idle_cycle("add_after");

    // (3 - 5) * 2 wraps
    do_clear(1'b0, "clr1");
    push_tok(16'd3, "sub_p3");
    push_tok(16'd5, "sub_p5");
    op_tok(4'd1, "sub_op");
    check("sub_top_fffe", 32'(top), 32'hFFFE);
    push_tok(16'd2, "mul_p2");
    op_tok(4'd2, "mul_op");
    check("mul_top_fffc", 32'(top), 32'hFFFC);

    // divide by zero then pop
    do_clear(1'b0, "clr2");
    push_tok(16'd2, "div_p2");
    push_tok(16'd0, "div_p0");
    op_tok(4'd3, "div_op");
    check("div_code4", 32'(err_code), 32'd4);
    op_tok(4'd4, "pop_op");
    check("pop_top2", 32'(top), 32'd2);

    // overflow with back-to-back pushes, then fold with ADD
    do_clear(1'b0, "clr3");
    for (int i = 1; i <= 9; i++) push_tok(W'(i), $sformatf("ovf_p%0d", i));
    check("ovf_code1", 32'(err_code), 32'd1);
    for (int i = 0; i < 7; i++) op_tok(4'd0, $sformatf("fold%0d", i));
    check("fold_top36", 32'(top), 32'd36);

    // underflow, then unknown op keeps the first code, then clear
    do_clear(1'b0, "clr4");
    push_tok(16'd1, "uf_p1");
    op_tok(4'd0, "uf_add");
    op_tok(4'hA, "uf_unknown");
    check("uf_code2", 32'(err_code), 32'd2);
    push_tok(16'd9, "clrtok_p9");
    do_clear(1'b1, "clr_with_token");

    // reset during EXEC aborts the multiply
    push_tok(16'd6, "rst_p6");
    push_tok(16'd7, "rst_p7");
    in_valid = 1'b1;
    in_is_op = 1'b1;
    in_data  = 16'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_exec_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rv_during", 32'(result_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    m_err  = 1'b0;
    m_code = 3'd0;
    @(negedge clk);
    check("rst_rv_after", 32'(result_valid), 32'd0);
    check_state("rst_after");

    // randomized token stream
    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 45)
        push_tok(($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom),
                 $sformatf("rnd%0d_push", k));
      else if (sel < 88)
        op_tok(op_table[$urandom_range(0, 6)], $sformatf("rnd%0d_op", k));
      else if (sel < 95)
        idle_cycle($sformatf("rnd%0d_idle", k));
      else
        do_clear(1'($urandom_range(0, 1)), $sformatf("rnd%0d_clr", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
